// File: rtl/psram_arbiter.sv
// Round-robin burst arbiter sharing one PSRAM controller among NUM_REQ requesters.
// Define PSRAM_ARB_PRIO0_EN to give requester 0 absolute priority over the rest.
module psram_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 23
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_write,
    input  logic [NUM_REQ*DEPTH-1:0] req_addr,
    input  logic [NUM_REQ*9-1:0]     req_count,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       done,
    output logic [7:0]               rd_data,
    output logic [NUM_REQ-1:0]       rd_valid,
    input  logic [NUM_REQ*8-1:0]     wr_data,
    output logic [NUM_REQ-1:0]       wr_ready,
    output logic                     mem_start_read,
    output logic                     mem_start_write,
    output logic [8:0]               mem_count,
    output logic [DEPTH-1:0]         mem_address,
    input  logic [7:0]               mem_dout,
    input  logic                     mem_r_valid,
    output logic [7:0]               mem_din,
    input  logic                     mem_w_ready
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, GAP} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IW-1:0]      gnt;
    logic [IW-1:0]      last;
    logic [IW-1:0]      pick;
    logic [IW-1:0]      idx;
    logic               found;
    logic               dir;
    logic [DEPTH-1:0]   addr;
    logic [8:0]         cnt;
    logic [9:0]         rem;
    logic               beat;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [DEPTH-1:0]   sel_addr;
    logic [8:0]         sel_cnt;

    assign gnt_oh   = NUM_REQ'(1) << gnt;
    assign beat     = dir ? mem_w_ready : mem_r_valid;
    assign sel_addr = req_addr[int'(pick)*DEPTH +: DEPTH];
    assign sel_cnt  = req_count[int'(pick)*9 +: 9];

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IW'((int'(last) + i) % NUM_REQ);
`ifdef PSRAM_ARB_PRIO0_EN
            if (!found && idx != '0 && req_valid[idx]) begin
`else
            if (!found && req_valid[idx]) begin
`endif
                found = 1'b1;
                pick  = idx;
            end
        end
`ifdef PSRAM_ARB_PRIO0_EN
        if (req_valid[0]) begin
            found = 1'b1;
            pick  = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt  <= '0;
            last <= IW'(NUM_REQ - 1);
            dir  <= 1'b0;
            addr <= '0;
            cnt  <= '0;
            rem  <= '0;
        end else if (state == IDLE && found) begin
            gnt  <= pick;
            dir  <= req_write[pick];
            addr <= sel_addr;
            cnt  <= sel_cnt;
            rem  <= (sel_cnt == 9'd0) ? 10'd512 : {1'b0, sel_cnt};
`ifdef PSRAM_ARB_PRIO0_EN
            if (pick != '0) begin
                last <= pick;
            end
`else
            last <= pick;
`endif
        end else if (state == XFER && beat) begin
            rem <= rem - 10'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (found) state_nxt = ISSUE;
            ISSUE: state_nxt = XFER;
            XFER:  if (beat && rem == 10'd1) state_nxt = GAP;
            GAP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready       = '0;
        done            = '0;
        rd_valid        = '0;
        wr_ready        = '0;
        rd_data         = 8'd0;
        mem_din         = 8'd0;
        mem_start_read  = 1'b0;
        mem_start_write = 1'b0;
        unique case (state)
            ISSUE: begin
                req_ready       = gnt_oh;
                mem_start_read  = !dir;
                mem_start_write = dir;
            end
            XFER: begin
                rd_data  = mem_dout;
                mem_din  = wr_data[int'(gnt)*8 +: 8];
                rd_valid = (!dir && mem_r_valid) ? gnt_oh : '0;
                wr_ready = (dir && mem_w_ready) ? gnt_oh : '0;
            end
            GAP: done = gnt_oh;
            default: ;
        endcase
    end

    assign mem_count   = cnt;
    assign mem_address = addr;

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter: reset, single read/write, contention,
// priority and reset mid-burst, with a queue scoreboard for grants and bytes.
module tb_psram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_write;
    logic [91:0] req_addr;
    logic [35:0] req_count;
    logic [3:0]  req_ready;
    logic [3:0]  done;
    logic [7:0]  rd_data;
    logic [3:0]  rd_valid;
    logic [31:0] wr_data;
    logic [3:0]  wr_ready;
    logic        mem_start_read;
    logic        mem_start_write;
    logic [8:0]  mem_count;
    logic [22:0] mem_address;
    logic [7:0]  mem_dout;
    logic        mem_r_valid;
    logic [7:0]  mem_din;
    logic        mem_w_ready;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int exp_q[$];

    psram_arbiter #(.NUM_REQ(4), .DEPTH(23)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_count(req_count),
        .req_ready(req_ready),
        .done(done),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .wr_data(wr_data),
        .wr_ready(wr_ready),
        .mem_start_read(mem_start_read),
        .mem_start_write(mem_start_write),
        .mem_count(mem_count),
        .mem_address(mem_address),
        .mem_dout(mem_dout),
        .mem_r_valid(mem_r_valid),
        .mem_din(mem_din),
        .mem_w_ready(mem_w_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!(mem_start_read || mem_start_write)) begin
            if (n >= 64) begin
                chk("start_timeout", 32'(n), 32'd0);
                break;
            end
            tick();
            n++;
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_rdv"}, 32'(rd_valid), 32'd0);
        chk({tag, "_wrr"}, 32'(wr_ready), 32'd0);
        chk({tag, "_start"}, 32'({mem_start_read, mem_start_write}), 32'd0);
        chk({tag, "_count"}, 32'(mem_count), 32'd0);
        chk({tag, "_addr"}, 32'(mem_address), 32'd0);
        chk({tag, "_rdata"}, 32'(rd_data), 32'd0);
        chk({tag, "_din"}, 32'(mem_din), 32'd0);
    endtask

    initial begin
        int n;
        int g;
        int prev;
        int strobes;
        int bad;
        int dbad;

        rst_n       = 1'b0;
        req_valid   = 4'hF;
        req_write   = 4'h0;
        req_addr    = '0;
        req_count   = {9'd1, 9'd1, 9'd1, 9'd1};
        wr_data     = 32'hDEADBEEF;
        mem_dout    = 8'h5A;
        mem_r_valid = 1'b1;
        mem_w_ready = 1'b0;
        prev        = 0;

        // Reset with every requester pending
        tick();
        tick();
        chk_quiet("reset");
        rst_n = 1'b1;

        // Contention: 1-byte reads, beats always available
        exp_q = {0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            wait_start(n);
            if (i == 0) chk("first_grant_latency", 32'(n), 32'd1);
            else chk("cont_spacing", 32'(cyc - prev), 32'd4);
            prev = cyc;
            g = exp_q.pop_front();
            chk("cont_grant", 32'(req_ready), 32'(1) << g);
            chk("cont_start_rd", 32'(mem_start_read), 32'd1);
            tick();
            chk("cont_rdv", 32'(rd_valid), 32'(1) << g);
            tick();
            chk("cont_done", 32'(done), 32'(1) << g);
            if (i == 4) req_valid = 4'h0;
        end
        mem_r_valid = 1'b0;
        tick();
        tick();

        // Single read: requester 2, 3 bytes at 0x100
        req_addr[2*23 +: 23] = 23'h000100;
        req_count[2*9 +: 9]  = 9'd3;
        req_valid            = 4'b0100;
        wait_start(n);
        chk("rd_start_rd", 32'(mem_start_read), 32'd1);
        chk("rd_start_wr", 32'(mem_start_write), 32'd0);
        chk("rd_addr", 32'(mem_address), 32'h100);
        chk("rd_count", 32'(mem_count), 32'd3);
        chk("rd_ready", 32'(req_ready), 32'h4);
        req_valid            = 4'h0;
        req_addr[2*23 +: 23] = 23'h0003FF;
        req_count[2*9 +: 9]  = 9'd7;
        tick();
        chk("rd_start_once", 32'(mem_start_read), 32'd0);
        for (int b = 0; b < 3; b++) begin
            if (b == 1) begin
                mem_r_valid = 1'b0;
                mem_w_ready = 1'b1;
                #1;
                chk("rd_wrong_dir_wrr", 32'(wr_ready), 32'd0);
                chk("rd_wrong_dir_rdv", 32'(rd_valid), 32'd0);
                tick();
                mem_w_ready = 1'b0;
            end
            mem_r_valid = 1'b1;
            mem_dout    = 8'hA1 + 8'(b);
            exp_q.push_back(int'(mem_dout));
            #1;
            chk("rd_beat_valid", 32'(rd_valid), 32'h4);
            chk("rd_beat_data", 32'(rd_data), 32'(exp_q.pop_front()));
            chk("rd_beat_nodone", 32'(done), 32'd0);
            tick();
        end
        mem_r_valid = 1'b0;
        #1;
        chk("rd_done", 32'(done), 32'h4);
        chk("rd_addr_hold", 32'(mem_address), 32'h100);
        chk("rd_count_hold", 32'(mem_count), 32'd3);
        tick();
        chk("rd_done_once", 32'(done), 32'd0);

        // Single write: requester 1, count 0 means 512 bytes
        req_write[1]       = 1'b1;
        req_count[9 +: 9]  = 9'd0;
        req_addr[23 +: 23] = 23'h7FFFFF;
        req_valid          = 4'b0010;
        wait_start(n);
        chk("wr_start_wr", 32'(mem_start_write), 32'd1);
        chk("wr_start_rd", 32'(mem_start_read), 32'd0);
        chk("wr_count", 32'(mem_count), 32'd0);
        chk("wr_addr", 32'(mem_address), 32'h7FFFFF);
        chk("wr_ready_acc", 32'(req_ready), 32'h2);
        req_valid = 4'h0;
        strobes = 0;
        bad = 0;
        dbad = 0;
        for (int k = 0; k < 512; k++) begin
            tick();
            wr_data[15:8] = 8'($urandom);
            mem_w_ready   = 1'b1;
            exp_q.push_back(int'(wr_data[15:8]));
            #1;
            if (wr_ready === 4'b0010) strobes++;
            if (32'(mem_din) !== 32'(exp_q.pop_front())) bad++;
            if (done !== 4'h0) dbad++;
        end
        tick();
        chk("wr_no_extra_strobe", 32'(wr_ready), 32'd0);
        chk("wr_done", 32'(done), 32'h2);
        chk("wr_strobes", 32'(strobes), 32'd512);
        chk("wr_din_errors", 32'(bad), 32'd0);
        chk("wr_early_done", 32'(dbad), 32'd0);
        mem_w_ready  = 1'b0;
        req_write[1] = 1'b0;
        tick();

        // Reset during the 5th beat of a 16-byte read
        req_addr[2*23 +: 23] = 23'h000200;
        req_count[2*9 +: 9]  = 9'd16;
        req_valid            = 4'b0100;
        wait_start(n);
        chk("mid_ready", 32'(req_ready), 32'h4);
        req_valid = 4'h0;
        tick();
        mem_r_valid = 1'b1;
        for (int b = 0; b < 4; b++) tick();
        rst_n = 1'b0;
        tick();
        chk_quiet("mid_reset");
        rst_n       = 1'b1;
        mem_r_valid = 1'b0;
        dbad = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done !== 4'h0) dbad++;
        end
        chk("mid_no_done", 32'(dbad), 32'd0);
        req_addr[23 +: 23] = 23'h000055;
        req_count[9 +: 9]  = 9'd2;
        req_valid          = 4'b0010;
        wait_start(n);
        chk("post_rst_ready", 32'(req_ready), 32'h2);
        chk("post_rst_addr", 32'(mem_address), 32'h55);
        chk("post_rst_count", 32'(mem_count), 32'd2);
        req_valid   = 4'h0;
        tick();
        mem_r_valid = 1'b1;
        tick();
        tick();
        mem_r_valid = 1'b0;
        #1;
        chk("post_rst_done", 32'(done), 32'h2);

        // Priority: requesters 0 and 3 always pending, fresh reset
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        req_write   = 4'h0;
        req_count   = {9'd1, 9'd1, 9'd1, 9'd1};
        mem_r_valid = 1'b1;
        req_valid   = 4'b1001;
`ifdef PSRAM_ARB_PRIO0_EN
        exp_q = {0, 0, 0, 0};
`else
        exp_q = {0, 3, 0, 3};
`endif
        for (int i = 0; i < 4; i++) begin
            wait_start(n);
            g = exp_q.pop_front();
            chk("prio_grant", 32'(req_ready), 32'(1) << g);
            tick();
            tick();
            chk("prio_done", 32'(done), 32'(1) << g);
            if (i == 3) req_valid = 4'h0;
        end
        mem_r_valid = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
